// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the forwarding/hazard control slice.
//   DEFAULT_REG_ADDR_W : default register index width
//   SEL_*              : EX operand mux select encodings
//   reg_addr_t         : register index type used inside the tracking entries
//   track_entry_t      : {valid, dest, writes, is_load} for one pipeline stage
// ---------------------------------------------------------------------------
package pipeline_pkg;

   localparam int DEFAULT_REG_ADDR_W = 5;

   localparam logic [1:0] SEL_REGFILE = 2'b00;
   localparam logic [1:0] SEL_MEM     = 2'b01;
   localparam logic [1:0] SEL_WB      = 2'b10;

   typedef logic [DEFAULT_REG_ADDR_W-1:0] reg_addr_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t dest;
      logic      writes;
      logic      is_load;
   } track_entry_t;

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// forwarding_hazard_unit_if
// Bundles the ID-stage instruction description going into the hazard unit
// and the forwarding selects / stall information coming back out.
//   master : the pipeline side (drives ID fields and flush)
//   slave  : the forwarding/hazard unit (drives selects, stall, stall_count)
// ---------------------------------------------------------------------------
interface forwarding_hazard_unit_if
   import pipeline_pkg::*;
#(
   parameter int REG_ADDR_W  = DEFAULT_REG_ADDR_W,
   parameter int STALL_CNT_W = 16
);

   logic                   id_valid;
   logic [REG_ADDR_W-1:0]  id_src1;
   logic                   id_src1_used;
   logic [REG_ADDR_W-1:0]  id_src2;
   logic                   id_src2_used;
   logic [REG_ADDR_W-1:0]  id_store_src;
   logic                   id_is_store;
   logic [REG_ADDR_W-1:0]  id_dest;
   logic                   id_writes;
   logic                   id_is_load;
   logic                   flush;
   logic [1:0]             input1_select;
   logic [1:0]             input2_select;
   logic [1:0]             store_select;
   logic                   stall;
   logic [STALL_CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
             id_store_src, id_is_store, id_dest, id_writes, id_is_load, flush,
      input  input1_select, input2_select, store_select, stall, stall_count
   );

   modport slave (
      input  id_valid, id_src1, id_src1_used, id_src2, id_src2_used,
             id_store_src, id_is_store, id_dest, id_writes, id_is_load, flush,
      output input1_select, input2_select, store_select, stall, stall_count
   );

endinterface

// File: rtl/fwd_select_logic.sv
// ---------------------------------------------------------------------------
// fwd_select_logic
// Combinational comparator for one source operand against the in-flight
// EX and MEM producers.
//   used      : the operand is really read from the register file
//   src       : source register index
//   ex_entry  : producer that will be in MEM when the consumer executes
//   mem_entry : producer that will be in WB when the consumer executes
//   sel       : resulting EX mux select
// ---------------------------------------------------------------------------
module fwd_select_logic
   import pipeline_pkg::*;
(
   input  logic         used,
   input  reg_addr_t    src,
   input  track_entry_t ex_entry,
   input  track_entry_t mem_entry,
   output logic [1:0]   sel
);

   // A load in MEM has its data by WB, so its load flag does not matter here.
   logic unused_mem_load;
   assign unused_mem_load = mem_entry.is_load;

   // Nearest producer wins. A load sitting in EX cannot be forwarded from
   // MEM because its data is not ready yet; that case is the stall path.
   // Register 0 is hard-wired, so it never forwards.
   always_comb begin
      sel = SEL_REGFILE;
      if (used && (src != '0)) begin
         if (ex_entry.valid && ex_entry.writes && !ex_entry.is_load &&
             (ex_entry.dest == src)) begin
            sel = SEL_MEM;
         end else if (mem_entry.valid && mem_entry.writes &&
                      (mem_entry.dest == src)) begin
            sel = SEL_WB;
         end
      end
   end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// ---------------------------------------------------------------------------
// forwarding_hazard_unit
// Tracks destination registers of instructions in EX and MEM, produces the
// registered EX operand forwarding selects for the instruction leaving ID,
// raises a one-cycle load-use stall and counts stall cycles (saturating).
//   clock2   : pipeline clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : ID instruction fields, flush, selects, stall, stall_count
// REG_ADDR_W must not exceed pipeline_pkg::DEFAULT_REG_ADDR_W.
// ---------------------------------------------------------------------------
module forwarding_hazard_unit
   import pipeline_pkg::*;
#(
   parameter int REG_ADDR_W  = DEFAULT_REG_ADDR_W,
   parameter int STALL_CNT_W = 16
) (
   input logic                      clock2,
   input logic                      reset_n,
   forwarding_hazard_unit_if.slave  bus
);

   logic [REG_ADDR_W-1:0]  raw_src1, raw_src2, raw_store_src, raw_dest;
   reg_addr_t              src1, src2, store_src;
   track_entry_t           ex_entry, mem_entry, id_entry;
   logic [1:0]             sel1_next, sel2_next, store_sel_next;
   logic [1:0]             sel1_q, sel2_q, store_sel_q;
   logic [STALL_CNT_W-1:0] stall_count_q;
   logic                   src_match, stall_now, advance;

   assign raw_src1      = bus.id_src1;
   assign raw_src2      = bus.id_src2;
   assign raw_store_src = bus.id_store_src;
   assign raw_dest      = bus.id_dest;
   assign src1          = reg_addr_t'(raw_src1);
   assign src2          = reg_addr_t'(raw_src2);
   assign store_src     = reg_addr_t'(raw_store_src);

   // Load-use detection against the EX entry only: one bubble is enough
   // because the load reaches MEM next cycle and then forwards from WB.
   // Flush kills the ID instruction, so it overrides any stall.
   always_comb begin
      src_match = (bus.id_src1_used && (src1 == ex_entry.dest)) ||
                  (bus.id_src2_used && (src2 == ex_entry.dest)) ||
                  (bus.id_is_store  && (store_src == ex_entry.dest));
      stall_now = bus.id_valid && !bus.flush && ex_entry.valid &&
                  ex_entry.writes && ex_entry.is_load &&
                  (ex_entry.dest != '0) && src_match;
      advance   = bus.id_valid && !bus.flush && !stall_now;
      id_entry  = '{valid:   1'b1,
                    dest:    reg_addr_t'(raw_dest),
                    writes:  bus.id_writes,
                    is_load: bus.id_is_load};
   end

   fwd_select_logic u_sel1 (
      .used(bus.id_src1_used), .src(src1),
      .ex_entry(ex_entry), .mem_entry(mem_entry), .sel(sel1_next)
   );

   fwd_select_logic u_sel2 (
      .used(bus.id_src2_used), .src(src2),
      .ex_entry(ex_entry), .mem_entry(mem_entry), .sel(sel2_next)
   );

   fwd_select_logic u_store_sel (
      .used(bus.id_is_store), .src(store_src),
      .ex_entry(ex_entry), .mem_entry(mem_entry), .sel(store_sel_next)
   );

   // Tracking pipeline: EX shifts into MEM every edge; EX takes the ID
   // instruction only when it really advances, otherwise a bubble.
   always_ff @(posedge clock2 or negedge reset_n) begin
      if (!reset_n) begin
         ex_entry  <= '0;
         mem_entry <= '0;
      end else begin
         mem_entry <= ex_entry;
         ex_entry  <= advance ? id_entry : '0;
      end
   end

   // Selects are captured at the same edge the instruction enters EX, so
   // they line up with it; bubbles get register-file selects.
   always_ff @(posedge clock2 or negedge reset_n) begin
      if (!reset_n) begin
         sel1_q      <= SEL_REGFILE;
         sel2_q      <= SEL_REGFILE;
         store_sel_q <= SEL_REGFILE;
      end else begin
         sel1_q      <= advance ? sel1_next      : SEL_REGFILE;
         sel2_q      <= advance ? sel2_next      : SEL_REGFILE;
         store_sel_q <= advance ? store_sel_next : SEL_REGFILE;
      end
   end

   // Stall performance counter, holds at all-ones instead of wrapping.
   always_ff @(posedge clock2 or negedge reset_n) begin
      if (!reset_n) begin
         stall_count_q <= '0;
      end else if (stall_now && (stall_count_q != '1)) begin
         stall_count_q <= stall_count_q + STALL_CNT_W'(1);
      end
   end

   assign bus.input1_select = sel1_q;
   assign bus.input2_select = sel2_q;
   assign bus.store_select  = store_sel_q;
   assign bus.stall         = stall_now;
   assign bus.stall_count   = stall_count_q;

endmodule

// File: doc/forwarding_hazard_unit.md
Name:
forwarding_hazard_unit

Overview:
- Control-side counterpart of the execute stage's operand muxes.
- Tracks the destination registers of in-flight instructions through the EX and MEM stages.
- Compares them against the source registers of the instruction in ID and generates registered forwarding selects (input1_select, input2_select, store_select) valid for the cycle in which that instruction executes.
- Detects load-use hazards, asserts a one-cycle stall with bubble insertion, and keeps a saturating stall counter.

Parameters:
REG_ADDR_W, 5, register index width
STALL_CNT_W, 16, width of stall performance counter

Ports:
clock2  in  1  pipeline clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_src1  in  REG_ADDR_W  ALU operand 1 source register
id_src1_used  in  1  operand 1 read from register file
id_src2  in  REG_ADDR_W  ALU operand 2 source register
id_src2_used  in  1  operand 2 read from register file
id_store_src  in  REG_ADDR_W  store-data source register
id_is_store  in  1  instruction is a store
id_dest  in  REG_ADDR_W  destination register
id_writes  in  1  instruction writes id_dest
id_is_load  in  1  instruction is a load (data available only at WB forwarding)
flush  in  1  kill instruction in ID (branch redirect)
input1_select  out  2  EX operand-1 mux select
input2_select  out  2  EX operand-2 mux select
store_select  out  2  EX store-data mux select
stall  out  1  hold PC and IF/ID this cycle
stall_count  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Select encoding: 00 = register-file value, 01 = MEM result, 10 = WB result. 11 is never driven.
- Reset (asynchronous, reset_n low): all selects 00, stall_count 0, EX/MEM tracking entries invalid. stall is 0 because it derives from the invalid EX entry.
- Tracking entries:
  - ex_entry and mem_entry each hold {valid, dest, writes, is_load}.
  - On each edge: mem_entry <= ex_entry.
  - ex_entry <= ID fields if (id_valid && !stall && !flush), else bubble (valid=0).
- stall (combinational):
  - Asserted when id_valid && !flush && ex.valid && ex.writes && ex.is_load && ex.dest != 0.
  - Plus a match against at least one used source: (id_src1_used && id_src1 == ex.dest) || (id_src2_used && id_src2 == ex.dest) || (id_is_store && id_store_src == ex.dest).
- Select computation, per source, registered at the edge the instruction enters EX:
  - if used && src != 0 && ex.valid && ex.writes && !ex.is_load && ex.dest == src -> 01
  - else if used && src != 0 && mem.valid && mem.writes && mem.dest == src -> 10
  - else -> 00
  - The EX entry becomes MEM and the MEM entry becomes WB at that same edge, so the nearest producer wins and EX has priority.
- Bubble cycles: when no instruction enters EX (stall, flush, or !id_valid), all selects are registered as 00.
- Latency: selects valid exactly one cycle after ID presentation, aligned with the instruction in EX.
- Load-use: exactly one stall cycle. The next cycle the load sits in MEM, no stall is raised, and the consumer gets select 10.
- Register 0: never forwarded and never causes a stall.
- flush and a stall condition in the same cycle: flush wins. stall=0 and a bubble enters EX.
- stall_count: increments on every cycle stall=1 and saturates at all-ones, with no wrap.
- Reset mid-stall: tracking is cleared immediately, stall drops asynchronously, and the held instruction is then re-presented by ID.

Decomposition:
- Shared package pipeline_pkg holds:
  - select constants: SEL_REGFILE=2'b00, SEL_MEM=2'b01, SEL_WB=2'b10
  - the tracking-entry struct type
  - REG_ADDR_W default
- One natural sub-module, fwd_select_logic: a combinational src-vs-entries comparator producing one 2-bit select. It is instantiated three times.

Test Plan:
- Back-to-back ALU dependency: add r3 then sub r4,r3,r1 -> input1_select=01 in sub's EX cycle, input2_select=00, no stall.
- Distance-2 dependency: add r3, nop, or r5,r2,r3 -> input2_select=10. If both EX and MEM write r3, select=01.
- Load-use: lw r6 then add r7,r6,r6 -> stall=1 for one cycle, both selects 00 in bubble cycle, then 10/10; stall_count=1.
- Store data: add r8 then sw r8 -> store_select=01; r0 producer/consumer -> all selects 00, no stall.
- Flush during load-use: lw r6, add r7,r6,r0 with flush=1 -> stall=0, bubble, selects 00, stall_count unchanged.
- Counter saturation and reset: force 65540 stall cycles -> stall_count holds 16'hFFFF; pulse reset_n low mid-run -> selects 00 and count 0 immediately.
